// File: rtl/vga_text_pkg.sv
// Shared constants and helpers for the VGA text overlays: glyph geometry,
// colours, digit placement and the segment-style digit font.
package vga_text_pkg;

  localparam int         GLYPH_W     = 8;
  localparam int         GLYPH_H     = 16;
  localparam logic [3:0] BLANK_CODE  = 4'hF;
  localparam logic [11:0] COLOR_BLACK = 12'h000;
  localparam logic [11:0] COLOR_CYAN  = 12'h0FF;

  typedef enum logic {PHASE_HIDE = 1'b0, PHASE_SHOW = 1'b1} blink_phase_e;

  function automatic int digit_x0(input int k, input int x0, input int dw,
                                  input int group, input int gap);
    return x0 + k * dw + (k / group) * gap;
  endfunction

  // Segment order {a,b,c,d,e,f,g}; codes above 9 light nothing.
  function automatic logic [6:0] digit_segments(input logic [3:0] code);
    case (code)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [7:0] font_row(input logic [3:0] code, input logic [3:0] row);
    logic [6:0] seg;
    logic [7:0] bits;
    seg = digit_segments(code);
    if (row < 4'd2)       bits = seg[6] ? 8'h7E : 8'h00;
    else if (row < 4'd7)  bits = (seg[1] ? 8'hC0 : 8'h00) | (seg[5] ? 8'h03 : 8'h00);
    else if (row < 4'd9)  bits = seg[0] ? 8'h7E : 8'h00;
    else if (row < 4'd14) bits = (seg[2] ? 8'hC0 : 8'h00) | (seg[4] ? 8'h03 : 8'h00);
    else                  bits = seg[3] ? 8'h7E : 8'h00;
    return bits;
  endfunction

endpackage

// File: rtl/digit_font_rom.sv
// Synchronous digit font ROM: one 8-pixel glyph row per {code,row},
// registered output cleared by reset.
module digit_font_rom
  import vga_text_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] code,
  input  logic [3:0] row,
  output logic [7:0] data
);

  always_ff @(posedge clk) begin
    if (reset) data <= 8'h00;
    else       data <= font_row(code, row);
  end

endmodule

// File: rtl/bcd_field_vga_overlay.sv
// Renders a frame-synchronous snapshot of N_DIGITS BCD digits as scaled
// glyphs with group gaps and a blinking edit cursor; fixed 2-cycle latency.
module bcd_field_vga_overlay
  import vga_text_pkg::*;
#(
  parameter int          N_DIGITS     = 6,
  parameter int          GROUP        = 2,
  parameter int          GROUP_GAP    = 96,
  parameter int          X0           = 160,
  parameter int          Y0           = 192,
  parameter int          SCALE_LOG2   = 2,
  parameter logic [11:0] FG_COLOR     = COLOR_CYAN,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  video_on,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  logic                  frame_tick,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  cursor_en,
  input  logic [2:0]            cursor_idx,
  output logic [11:0]           rgb_out
);

  localparam int          DW        = GLYPH_W << SCALE_LOG2;
  localparam int          DH        = GLYPH_H << SCALE_LOG2;
  localparam int          IW        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int          FW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [9:0]  Y0V       = 10'(Y0);
  localparam logic [10:0] YEND      = 11'(Y0 + DH);

  logic [4*N_DIGITS-1:0] snap;
  logic [FW-1:0]         fcnt;
  blink_phase_e          phase;
  logic                  cursor_en_d;

  logic [N_DIGITS-1:0]   hit_vec;
  logic [2:0]            col_vec [N_DIGITS];
  logic [9:0]            dy;
  logic                  in_rows;
  logic [IW-1:0]         sel;
  logic                  hit_any;
  logic [3:0]            digit;
  logic                  cursor_hide;
  logic [3:0]            code;

  logic                  hit_s1, von_s1;
  logic [3:0]            code_s1, row_s1;
  logic [2:0]            col_s1, col_d;
  logic                  hit_d, von_d;
  logic [7:0]            font_data;

  // Digits are latched only at vertical blank so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset)           snap <= '0;
    else if (frame_tick) snap <= digits_in;
  end

  // Releasing edit mode restarts the blink with the cursor digit visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt        <= '0;
      phase       <= PHASE_SHOW;
      cursor_en_d <= 1'b0;
    end else begin
      cursor_en_d <= cursor_en;
      if (cursor_en_d && !cursor_en) begin
        fcnt  <= '0;
        phase <= PHASE_SHOW;
      end else if (frame_tick) begin
        if (fcnt == FCNT_LAST) begin
          fcnt  <= '0;
          phase <= (phase == PHASE_SHOW) ? PHASE_HIDE : PHASE_SHOW;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  assign dy      = pix_y - Y0V;
  assign in_rows = (pix_y >= Y0V) && ({1'b0, pix_y} < YEND);

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_cell
    localparam logic [9:0]  XK = 10'(digit_x0(k, X0, DW, GROUP, GROUP_GAP));
    localparam logic [10:0] XE = 11'(digit_x0(k, X0, DW, GROUP, GROUP_GAP) + DW);
    logic [9:0] dx;
    assign dx         = pix_x - XK;
    assign hit_vec[k] = in_rows && (pix_x >= XK) && ({1'b0, pix_x} < XE);
    assign col_vec[k] = 3'(dx >> SCALE_LOG2);
  end

  // Scanning from the top down leaves the lowest hit index selected.
  always_comb begin
    sel     = '0;
    hit_any = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel     = IW'(i);
        hit_any = 1'b1;
      end
    end
  end

  assign digit       = snap[4*sel +: 4];
  assign cursor_hide = cursor_en && (phase == PHASE_HIDE) && (32'(cursor_idx) == 32'(sel));
  assign code        = ((digit > 4'd9) || cursor_hide) ? BLANK_CODE : digit;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_s1  <= 1'b0;
      von_s1  <= 1'b0;
      code_s1 <= '0;
      row_s1  <= '0;
      col_s1  <= '0;
    end else begin
      hit_s1  <= hit_any;
      von_s1  <= video_on & enable;
      code_s1 <= code;
      row_s1  <= 4'(dy >> SCALE_LOG2);
      col_s1  <= col_vec[sel];
    end
  end

  digit_font_rom u_rom (
    .clk   (clk),
    .reset (reset),
    .code  (code_s1),
    .row   (row_s1),
    .data  (font_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      col_d <= '0;
      hit_d <= 1'b0;
      von_d <= 1'b0;
    end else begin
      col_d <= col_s1;
      hit_d <= hit_s1;
      von_d <= von_s1;
    end
  end

  assign rgb_out = (von_d && hit_d && font_data[3'd7 - col_d]) ? FG_COLOR : COLOR_BLACK;

endmodule

// File: tb/tb_bcd_field_vga_overlay.sv
// Randomised and directed bench for bcd_field_vga_overlay: two instances
// (default geometry, and 4 digits at scale 2) against a pixel-level model.
module tb_bcd_field_vga_overlay;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        video_on = 1'b1;
  logic        frame_tick = 1'b0;
  logic        cursor_en = 1'b0;
  logic [2:0]  cursor_idx = 3'd0;
  logic [9:0]  pix_x = 10'd0;
  logic [9:0]  pix_y = 10'd0;
  logic [23:0] digits_a = 24'h0;
  logic [15:0] digits_b = 16'h0;
  logic [11:0] rgb_a, rgb_b;

  logic [23:0] snap_a = 24'h0;
  logic [15:0] snap_b = 16'h0;
  int          ticks = 0;
  int          checks = 0;
  int          failures = 0;

  string seg_tab [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                          "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  always #5 clk = ~clk;

  bcd_field_vga_overlay #(.N_DIGITS(6), .GROUP(2), .BLINK_FRAMES(2)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .video_on(video_on),
    .pix_x(pix_x), .pix_y(pix_y), .frame_tick(frame_tick), .digits_in(digits_a),
    .cursor_en(cursor_en), .cursor_idx(cursor_idx), .rgb_out(rgb_a)
  );

  bcd_field_vga_overlay #(.N_DIGITS(4), .GROUP(4), .SCALE_LOG2(1), .BLINK_FRAMES(2)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .video_on(video_on),
    .pix_x(pix_x), .pix_y(pix_y), .frame_tick(frame_tick), .digits_in(digits_b),
    .cursor_en(cursor_en), .cursor_idx(cursor_idx), .rgb_out(rgb_b)
  );

  function automatic bit has_seg(input int d, input byte s);
    string t;
    t = seg_tab[d];
    for (int i = 0; i < t.len(); i++) if (t[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  // Glyph: horizontal bars span columns 1..6, vertical bars are two columns wide.
  function automatic bit glyph_lit(input int d, input int row, input int col);
    bit horiz, left, right;
    horiz = (col >= 1) && (col <= 6);
    left  = (col <= 1);
    right = (col >= 6);
    if (row < 2)  return has_seg(d, "a") && horiz;
    if (row < 7)  return (has_seg(d, "f") && left) || (has_seg(d, "b") && right);
    if (row < 9)  return has_seg(d, "g") && horiz;
    if (row < 14) return (has_seg(d, "e") && left) || (has_seg(d, "c") && right);
    return has_seg(d, "d") && horiz;
  endfunction

  function automatic logic [11:0] model_rgb(input int n, input int grp, input int s,
                                            input logic [23:0] sv, input int x, input int y,
                                            input bit vis, input bit hide, input int cidx);
    int dw, dh, xk, d;
    dw = 8 << s;
    dh = 16 << s;
    if (!vis || y < 192 || y >= 192 + dh) return 12'h000;
    for (int k = 0; k < n; k++) begin
      xk = 160 + k * dw + (k / grp) * 96;
      if (x >= xk && x < xk + dw) begin
        d = int'(sv[4*k +: 4]);
        if (d > 9 || (hide && cidx == k)) return 12'h000;
        return glyph_lit(d, (y - 192) >> s, (x - xk) >> s) ? 12'h0FF : 12'h000;
      end
    end
    return 12'h000;
  endfunction

  function automatic bit hide_now();
    return cursor_en && (((ticks / 2) % 2) == 1);
  endfunction

  function automatic logic [11:0] exp_a(input int x, input int y);
    return model_rgb(6, 2, 2, snap_a, x, y, video_on && enable, hide_now(), int'(cursor_idx));
  endfunction

  function automatic logic [11:0] exp_b(input int x, input int y);
    return model_rgb(4, 4, 1, {8'h00, snap_b}, x, y, video_on && enable, hide_now(), int'(cursor_idx));
  endfunction

  task automatic show(input int x, input int y);
    @(negedge clk);
    pix_x = 10'(x);
    pix_y = 10'(y);
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    snap_a = digits_a;
    snap_b = digits_b;
    ticks++;
  endtask

  task automatic test_reset();
    pix_x = 10'd164;
    pix_y = 10'd193;
    digits_a = 24'h888888;
    digits_b = 16'h8888;
    frame_tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rgb_a !== 12'h000) begin failures++; $display("[TB] FAIL reset_a: got %h expected 000", rgb_a); end
    checks++;
    if (rgb_b !== 12'h000) begin failures++; $display("[TB] FAIL reset_b: got %h expected 000", rgb_b); end
    @(negedge clk);
    frame_tick = 1'b0;
    reset = 1'b0;
    snap_a = 24'h0;
    snap_b = 16'h0;
    ticks = 0;
    digits_a = 24'h612152;
    digits_b = 16'h1947;
    pulse_tick();
  endtask

  task automatic test_digit_rows();
    logic [11:0] e;
    for (int yy = 192; yy <= 200; yy += 8) begin
      for (int x = 160; x < 224; x += 2) begin
        show(x, yy);
        e = exp_a(x, yy);
        checks++;
        if (rgb_a !== e) begin failures++; $display("[TB] FAIL digit_rows (%0d,%0d): got %h expected %h", x, yy, rgb_a, e); end
      end
    end
  endtask

  task automatic test_group_gap();
    logic [11:0] e;
    for (int x = 222; x < 356; x += 3) begin
      show(x, 200);
      e = exp_a(x, 200);
      checks++;
      if (rgb_a !== e) begin failures++; $display("[TB] FAIL group_gap (%0d,200): got %h expected %h", x, rgb_a, e); end
    end
    show(319, 200);
    checks++;
    if (rgb_a !== 12'h000) begin failures++; $display("[TB] FAIL gap_edge x=319: got %h expected 000", rgb_a); end
  endtask

  task automatic test_snapshot();
    logic [11:0] e;
    digits_a = 24'h612158;
    for (int pass = 0; pass < 2; pass++) begin
      for (int r = 0; r < 16; r += 3) begin
        for (int c = 0; c < 8; c++) begin
          show(160 + 4 * c + 1, 192 + 4 * r + 2);
          e = exp_a(160 + 4 * c + 1, 192 + 4 * r + 2);
          checks++;
          if (rgb_a !== e) begin failures++; $display("[TB] FAIL snapshot pass%0d r%0d c%0d: got %h expected %h", pass, r, c, rgb_a, e); end
        end
      end
      if (pass == 0) pulse_tick();
    end
  endtask

  task automatic test_blink();
    logic [11:0] e;
    digits_a = 24'h618152;
    pulse_tick();
    @(negedge clk);
    cursor_en = 1'b1;
    cursor_idx = 3'd3;
    for (int f = 0; f < 6; f++) begin
      show(357, 193);
      e = exp_a(357, 193);
      checks++;
      if (rgb_a !== e) begin failures++; $display("[TB] FAIL blink idx3 frame%0d: got %h expected %h", f, rgb_a, e); end
      show(349, 200);
      e = exp_a(349, 200);
      checks++;
      if (rgb_a !== e) begin failures++; $display("[TB] FAIL blink neighbour frame%0d: got %h expected %h", f, rgb_a, e); end
      pulse_tick();
    end
    @(negedge clk);
    cursor_idx = 3'd6;
    for (int f = 0; f < 4; f++) begin
      show(357, 193);
      checks++;
      if (rgb_a !== 12'h0FF) begin failures++; $display("[TB] FAIL blink idx6 frame%0d: got %h expected 0ff", f, rgb_a); end
      pulse_tick();
    end
    @(negedge clk);
    cursor_en = 1'b0;
    ticks = 0;
  endtask

  task automatic test_blank_enable();
    logic [11:0] e;
    digits_a = 24'h61815A;
    pulse_tick();
    show(165, 193);
    checks++;
    if (rgb_a !== 12'h000) begin failures++; $display("[TB] FAIL blank_nibble: got %h expected 000", rgb_a); end
    video_on = 1'b0;
    show(197, 193);
    checks++;
    if (rgb_a !== 12'h000) begin failures++; $display("[TB] FAIL video_off: got %h expected 000", rgb_a); end
    video_on = 1'b1;
    enable = 1'b0;
    show(197, 193);
    checks++;
    if (rgb_a !== 12'h000) begin failures++; $display("[TB] FAIL enable_off: got %h expected 000", rgb_a); end
    enable = 1'b1;
    show(197, 193);
    e = exp_a(197, 193);
    checks++;
    if (rgb_a !== e) begin failures++; $display("[TB] FAIL enable_on: got %h expected %h", rgb_a, e); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rgb_a !== 12'h000) begin failures++; $display("[TB] FAIL midline_reset: got %h expected 000", rgb_a); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    snap_a = 24'h0;
    snap_b = 16'h0;
    ticks = 0;
    @(posedge clk);
    #1;
    checks++;
    if (rgb_a !== 12'h000) begin failures++; $display("[TB] FAIL refill_1clk: got %h expected 000", rgb_a); end
    @(posedge clk);
    #1;
    e = exp_a(197, 193);
    checks++;
    if (rgb_a !== e) begin failures++; $display("[TB] FAIL refill_2clk: got %h expected %h", rgb_a, e); end
    digits_a = 24'h612152;
    pulse_tick();
  endtask

  task automatic test_scale_small();
    logic [11:0] e;
    int ys [5] = '{192, 200, 211, 223, 224};
    for (int j = 0; j < 5; j++) begin
      for (int x = 156; x < 228; x += 3) begin
        show(x, ys[j]);
        e = exp_b(x, ys[j]);
        checks++;
        if (rgb_b !== e) begin failures++; $display("[TB] FAIL scale_b (%0d,%0d): got %h expected %h", x, ys[j], rgb_b, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] qa [$];
    logic [11:0] qb [$];
    logic [11:0] ea, eb;
    int x, y;
    bit prev_cur;
    for (int i = 0; i < 1502; i++) begin
      @(negedge clk);
      if (qa.size() == 2) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        checks++;
        if (rgb_a !== ea) begin failures++; $display("[TB] FAIL stream_a cycle %0d: got %h expected %h", i, rgb_a, ea); end
        checks++;
        if (rgb_b !== eb) begin failures++; $display("[TB] FAIL stream_b cycle %0d: got %h expected %h", i, rgb_b, eb); end
      end
      if (i >= 1500) begin
        frame_tick = 1'b0;
        continue;
      end
      x = $urandom_range(150, 720);
      y = $urandom_range(185, 265);
      video_on   = ($urandom_range(0, 9) != 0);
      enable     = ($urandom_range(0, 9) != 0);
      frame_tick = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0)
        for (int k = 0; k < 6; k++) digits_a[4*k +: 4] = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 29) == 0)
        for (int k = 0; k < 4; k++) digits_b[4*k +: 4] = 4'($urandom_range(0, 11));
      prev_cur = cursor_en;
      if (!frame_tick && $urandom_range(0, 39) == 0) cursor_en = ~cursor_en;
      if ($urandom_range(0, 49) == 0) cursor_idx = 3'($urandom_range(0, 7));
      pix_x = 10'(x);
      pix_y = 10'(y);
      qa.push_back(exp_a(x, y));
      qb.push_back(exp_b(x, y));
      if (frame_tick) begin
        snap_a = digits_a;
        snap_b = digits_b;
        ticks++;
      end
      if (prev_cur && !cursor_en) ticks = 0;
    end
  endtask

  initial begin
    test_reset();
    test_digit_rows();
    test_group_gap();
    test_snapshot();
    test_blink();
    test_blank_enable();
    test_scale_small();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
